// File: rtl/sub_word_rcon.sv
`default_nettype none
//============================================================================
// Module   : sub_word_rcon
// Brief    : AES key-expansion helper: 1-cycle SubWord plus Rcon XOR on byte 3.
//            Optional macro SUB_WORD_RCON_ROTWORD_EN applies RotWord first.
// Revision : 1.0 - initial release
//============================================================================

module sub_word_rcon_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    // Entry for input value a sits at bits [(255-a)*8 +: 8]; (255-a)*8 == {~a, 3'b000}.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_SBOX[{~i_byte, 3'b000} +: 8];
endmodule

module sub_word_rcon (
    input  logic        CLOCK_50,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] word_in,
    input  logic [3:0]  round,
    output logic        out_valid,
    output logic [31:0] sub_out,
    output logic [31:0] word_out
);
    logic [31:0] w_pre_sub;
    logic [31:0] w_sub;
    logic [7:0]  w_rcon;
    logic        r_valid;
    logic [31:0] r_sub;
    logic [31:0] r_word;

`ifdef SUB_WORD_RCON_ROTWORD_EN
    assign w_pre_sub = {word_in[23:0], word_in[31:24]};
`else
    assign w_pre_sub = word_in;
`endif

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            sub_word_rcon_sbox u_sbox (
                .i_byte (w_pre_sub[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    // Rounds 10..15 have no round constant, so word_out degenerates to sub_out.
    always_comb begin
        w_rcon = 8'h00;
        case (round)
            4'd0:    w_rcon = 8'h01;
            4'd1:    w_rcon = 8'h02;
            4'd2:    w_rcon = 8'h04;
            4'd3:    w_rcon = 8'h08;
            4'd4:    w_rcon = 8'h10;
            4'd5:    w_rcon = 8'h20;
            4'd6:    w_rcon = 8'h40;
            4'd7:    w_rcon = 8'h80;
            4'd8:    w_rcon = 8'h1b;
            4'd9:    w_rcon = 8'h36;
            default: w_rcon = 8'h00;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sub   <= 32'h0;
            r_word  <= 32'h0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_sub  <= w_sub;
                r_word <= w_sub ^ {w_rcon, 24'h0};
            end
        end
    end

    assign out_valid = r_valid;
    assign sub_out   = r_sub;
    assign word_out  = r_word;
endmodule

`default_nettype wire

// File: tb/tb_sub_word_rcon.sv
`default_nettype none
//============================================================================
// Module   : tb_sub_word_rcon
// Brief    : Directed + random scoreboard bench for sub_word_rcon.
// Revision : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps

module tb_sub_word_rcon;
    logic        CLOCK_50;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] word_in;
    logic [3:0]  round;
    logic        out_valid;
    logic [31:0] sub_out;
    logic [31:0] word_out;

    typedef struct packed {
        logic [31:0] sub;
        logic [31:0] word;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_sub;
    logic [31:0] last_word;
    int          n_checks;
    int          n_errors;

    sub_word_rcon dut (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .word_in   (word_in),
        .round     (round),
        .out_valid (out_valid),
        .sub_out   (sub_out),
        .word_out  (word_out)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    // Reference S-box built from GF(2^8) inversion and the affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] b);
        logic [7:0] inv, s;
        inv = 8'h0;
        for (int c = 1; c < 256; c++)
            if (gmul(b, 8'(c)) == 8'h01) inv = 8'(c);
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [7:0] ref_rcon(input logic [3:0] r);
        logic [7:0] v;
        if (r > 4'd9) return 8'h00;
        v = 8'h01;
        for (int i = 0; i < int'(r); i++) v = gmul(v, 8'h02);
        return v;
    endfunction

    function automatic exp_t model(input logic [31:0] w, input logic [3:0] r);
        logic [31:0] x;
        exp_t e;
`ifdef SUB_WORD_RCON_ROTWORD_EN
        x = {w[23:0], w[31:24]};
`else
        x = w;
`endif
        for (int i = 0; i < 4; i++) e.sub[8*i +: 8] = ref_sbox(x[8*i +: 8]);
        e.word = e.sub ^ {ref_rcon(r), 24'h0};
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] w, input logic [3:0] r);
        in_valid = 1'b1;
        word_in  = w;
        round    = r;
        if (rst_n) sb.push_back(model(w, r));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        word_in  = $urandom;
        round    = 4'($urandom_range(0, 15));
    endtask

    // Advance one edge and compare outputs against the scoreboard / hold values.
    task automatic tick(input string tag);
        logic was_valid;
        exp_t e;
        was_valid = in_valid && rst_n;
        @(posedge CLOCK_50);
        #1;
        chk({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, was_valid});
        if (was_valid) begin
            if (sb.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                chk({tag, ".sub_out"}, sub_out, e.sub);
                chk({tag, ".word_out"}, word_out, e.word);
                last_sub  = e.sub;
                last_word = e.word;
            end
        end else begin
            chk({tag, ".hold_sub"}, sub_out, last_sub);
            chk({tag, ".hold_word"}, word_out, last_word);
        end
    endtask

    initial begin
        logic [7:0] rcon_tab [0:15];
        rcon_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                     8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        n_checks  = 0;
        n_errors  = 0;
        last_sub  = 32'h0;
        last_word = 32'h0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        word_in   = 32'h0;
        round     = 4'h0;

        // Reset asserted between edges: outputs clear without a clock edge.
        #5 rst_n = 1'b0;
        #1;
        chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst.sub_out", sub_out, 32'h0);
        chk("rst.word_out", word_out, 32'h0);
        // Input offered while in reset is discarded.
        drive(32'h12345678, 4'd3);
        tick("rst_hold");
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        idle();
        tick("post_rst0");
        tick("post_rst1");

        // Known-answer vector.
        drive(32'h09cf4f3c, 4'd0);
        tick("kat");
`ifdef SUB_WORD_RCON_ROTWORD_EN
        chk("kat.sub_const", sub_out, 32'h8a84eb01);
        chk("kat.word_const", word_out, 32'h8b84eb01);
`else
        chk("kat.sub_const", sub_out, 32'h018a84eb);
        chk("kat.word_const", word_out, 32'h008a84eb);
`endif

        // Rcon sweep, back-to-back over all 16 rounds.
        for (int r = 0; r < 16; r++) begin
            drive(32'h52525252, 4'(r));
            tick("rcon");
            chk($sformatf("rcon%0d.byte3", r), {24'h0, word_out[31:24]}, {24'h0, rcon_tab[r]});
            chk($sformatf("rcon%0d.low", r), {8'h0, word_out[23:0]}, 32'h0);
        end

        // Back-to-back extremes at a round with no constant.
        drive(32'h00000000, 4'd15);
        tick("b2b0");
        chk("b2b0.const", word_out, 32'h63636363);
        drive(32'hffffffff, 4'd15);
        tick("b2b1");
        chk("b2b1.const", word_out, 32'h16161616);

        // Hold after a valid result.
        idle();
        tick("hold0");
        tick("hold1");

        // Random traffic with gaps.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) != 0) drive($urandom, 4'($urandom_range(0, 15)));
            else idle();
            tick("rand");
        end

        // Mid-stream reset: pending input is never captured.
        drive(32'hdeadbeef, 4'd1);
        tick("pre_mid");
        drive(32'hcafef00d, 4'd2);
        #4 rst_n = 1'b0;
        #1;
        sb.delete();
        last_sub  = 32'h0;
        last_word = 32'h0;
        chk("mid.out_valid", {31'h0, out_valid}, 32'h0);
        chk("mid.sub_out", sub_out, 32'h0);
        chk("mid.word_out", word_out, 32'h0);
        tick("mid_in_rst");
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        idle();
        tick("mid_rel0");
        tick("mid_rel1");
        drive(32'h00000001, 4'd9);
        tick("mid_first");
        idle();
        tick("mid_end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
